stream_demux: RTL
=================

// Module: stream_demux
//
// PURPOSE
// - Registered 1-to-N stream demultiplexer: the distributing counterpart of the 2:1 mux
//   used across the combinational labs. Accepts one valid/ready input stream tagged with
//   a destination select and delivers each word to exactly one of N_OUT output channels.
// - Sits between a single producer and N consumers in the sequential labs. Holds one word
//   at a time and supports full throughput (one word per clock) when the destination is ready.
//
// PARAMETERS
// - WIDTH  8  data word width in bits
// - N_OUT  4  number of output channels, >= 2
// - SEL_W  $clog2(N_OUT)  select width; derived localparam, not overridable
//
// PORTS
// - clk        in   1            rising-edge clock
// - rst        in   1            synchronous reset, active-high
// - in_valid   in   1            input word valid
// - in_ready   out  1            block can accept the input word this cycle
// - in_sel     in   SEL_W        destination channel; sampled with in_data
// - in_data    in   WIDTH        input word
// - out_valid  out  N_OUT        one-hot per-channel valid; all zero when empty
// - out_ready  in   N_OUT        per-channel ready
// - out_data   out  WIDTH        shared output data bus; meaningful only when |out_valid
// - sel_err    out  1            one-cycle pulse: accepted word had in_sel >= N_OUT
//
// BEHAVIOUR
// - Reset: rst high at a clk edge empties the holding register.
//   out_valid=0, out_data=0, sel_err=0. Any held word is discarded, including mid-transfer.
// - State machine: EMPTY, FULL (one holding register: data, sel).
// - Input transfer when in_valid && in_ready. Output transfer on channel k when
//   out_valid[k] && out_ready[k].
// - in_ready = EMPTY || (FULL && out_ready[held_sel]). Pure combinational, no dependence on in_valid.
// - Latency: an accepted word appears on out_valid/out_data the next cycle.
// - EMPTY -> FULL on an input transfer with valid sel. EMPTY stays EMPTY otherwise.
// - FULL with output transfer and simultaneous input transfer: stays FULL and loads the new word.
//   This is back-to-back operation with no bubble.
// - FULL with output transfer and no input transfer -> EMPTY.
// - FULL with no output transfer: hold data/sel stable, in_ready=0. Never drop or reorder a word.
// - out_valid[k] = FULL && (held_sel == k). At most one bit is set.
//   out_data holds its last value when EMPTY and does not clear.
// - Invalid sel (in_sel >= N_OUT, possible only when N_OUT is not a power of 2): the word is
//   still accepted per the in_ready rule but discarded, and is not loaded. sel_err pulses high
//   in the following cycle. State becomes EMPTY if the held word also left that cycle,
//   else keeps the held word.
// - Channel k's out_ready is ignored unless k is the held destination.
//   Ready on non-selected channels never causes a transfer.
// - in_data/in_sel are don't-care when in_valid=0.
//
// CONFIGURATION
// - DEMUX_STATS_EN defined: adds output port stat_cnt (out, N_OUT*16 bits).
//   Field k is [16*k +: 16], a 16-bit wrapping count of output transfers on channel k.
//   It wraps 0xFFFF -> 0x0000 and is cleared to 0 by rst. Invalid-sel drops are not counted.
// - DEMUX_STATS_EN undefined: stat_cnt port and counters absent; all other behaviour identical.
//
// TESTING
// - Reset: hold rst 2 cycles during a FULL state -> out_valid=0, out_data=0, sel_err=0, in_ready=1.
// - Single word: in_sel=2, in_data=0xA5, out_ready=4'b0100 -> next cycle out_valid=4'b0100,
//   out_data=0xA5; state empties after one cycle.
// - Backpressure: load sel=1 data=0x3C with out_ready=0 for 5 cycles -> out_valid=4'b0010 and
//   data stable, in_ready=0; raise out_ready[1] -> transfer, in_ready=1 the same cycle.
// - Streaming: 8 words, sels 0,1,2,3,0,1,2,3, all out_ready=1 -> one delivery per cycle in order,
//   each on the correct one-hot channel, no bubbles.
// - Wrong-channel ready: hold sel=3 word, out_ready=4'b0111 -> no transfer; word persists until
//   out_ready[3]=1.
// - Invalid sel (N_OUT=3): in_sel=3 accepted -> sel_err pulses one cycle, out_valid stays 0.
//   With DEMUX_STATS_EN, all stat_cnt fields are unchanged.
//   Separately, 65536 deliveries on channel 0 -> stat_cnt[15:0] wraps to 0.

Source files
------------

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N valid/ready demultiplexer built around a single holding register.
// Define DEMUX_STATS_EN to add per-channel 16-bit transfer counters on stat_cnt.
module stream_demux #(
    parameter  int WIDTH = 8,
    parameter  int N_OUT = 4,
    localparam int SEL_W = $clog2(N_OUT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic [N_OUT-1:0]     out_valid,
    input  logic [N_OUT-1:0]     out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 sel_err
`ifdef DEMUX_STATS_EN
    ,
    output logic [N_OUT*16-1:0]  stat_cnt
`endif
);

    // Handshake: a word moves across a port on a rising clk edge where that port's
    // valid and ready are both high; in_ready never looks at in_valid.
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   data_q;
    logic [SEL_W-1:0]   sel_q;
    logic               sel_err_q;
    logic               sel_ok;
    logic               in_fire;
    logic               out_fire;
    logic               load;

    // Only reachable as false when N_OUT is not a power of two.
    assign sel_ok = int'(in_sel) < N_OUT;

    always_comb begin
        state_d   = state_q;
        out_valid = '0;
        out_fire  = 1'b0;
        in_ready  = 1'b0;
        in_fire   = 1'b0;
        load      = 1'b0;

        if (state_q == S_FULL) begin
            out_valid[sel_q] = 1'b1;
            out_fire         = out_ready[sel_q];
        end
        in_ready = (state_q == S_EMPTY) || out_fire;
        in_fire  = in_valid && in_ready;
        load     = in_fire && sel_ok;

        case (state_q)
            S_EMPTY: begin
                if (load) state_d = S_FULL;
            end
            S_FULL: begin
                if (load)          state_d = S_FULL;
                else if (out_fire) state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_EMPTY;
            data_q    <= '0;
            sel_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_err_q <= in_fire && !sel_ok;
            if (load) begin
                data_q <= in_data;
                sel_q  <= in_sel;
            end
        end
    end

    // out_data keeps the last loaded word while empty.
    assign out_data = data_q;
    assign sel_err  = sel_err_q;

`ifdef DEMUX_STATS_EN
    logic [15:0] cnt_q [N_OUT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_OUT; k++) cnt_q[k] <= '0;
        end else if (out_fire) begin
            cnt_q[sel_q] <= cnt_q[sel_q] + 16'd1;
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_stat
        assign stat_cnt[16*g +: 16] = cnt_q[g];
    end
`endif

endmodule
